// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: bridges a 32-bit load/store port onto an 8-bit shared memory bus.
// Each byte, half or word access becomes a run of single-byte bus cycles.
// Loads are reassembled little-endian, with optional sign extension.
// The controller freezes while the bus is lent out (rdy low).
// Writes into the I/O window wait while the HCI output buffer is full.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rdy               bus grant; low freezes the controller
//   io_buffer_full    HCI output buffer full (holds I/O-window writes)
//   req_*             request handshake (valid/ready), we, size, signed, addr, wdata
//   resp_valid/rdata  one-cycle completion pulse and load result (zero for stores)
//   mem_a/wr/dout     bus address, write strobe, write byte
//   mem_din           bus read byte, valid one cycle after its address
module mem_byte_ctrl #(
    parameter int unsigned IO_SEL_HI = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        io_buffer_full,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic [2:0]  n_q;      // bytes in this access: 1, 2 or 4
    logic [2:0]  issue_q;  // next byte index to drive
    logic [2:0]  cap_q;    // next byte slot to capture
    logic        signed_q;
    logic        pend_q;   // previous cycle drove an address with the bus granted

    logic [2:0]  last_idx;
    logic [2:0]  rd_idx;
    logic [2:0]  byte_idx;
    logic [31:0] byte_addr;
    logic        is_io;
    logic        wr_fire;
    logic        sign_bit;

    always_comb begin
        last_idx  = n_q - 3'd1;
        // Once every byte has been issued, keep the last address on the bus.
        rd_idx    = (issue_q < n_q) ? issue_q : last_idx;
        byte_idx  = (state_q == StRead) ? rd_idx : issue_q;
        byte_addr = addr_q + {29'd0, byte_idx};
        is_io     = (byte_addr[IO_SEL_HI -: 2] == 2'b11);
        wr_fire   = (state_q == StWrite) && rdy && !(is_io && io_buffer_full);
        sign_bit  = signed_q & data_q[{last_idx[1:0], 3'b111}];
    end

    always_comb begin
        req_ready  = (state_q == StIdle) && rdy;
        resp_valid = (state_q == StResp);
        mem_wr     = wr_fire;
        mem_a      = '0;
        mem_dout   = '0;
        resp_rdata = '0;
        if (state_q == StRead || state_q == StWrite) begin
            mem_a = byte_addr;
        end
        if (state_q == StWrite) begin
            mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
        end
        if (state_q == StResp) begin
            case (n_q)
                3'd1:    resp_rdata = {{24{sign_bit}}, data_q[7:0]};
                3'd2:    resp_rdata = {{16{sign_bit}}, data_q[15:0]};
                default: resp_rdata = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            n_q      <= '0;
            issue_q  <= '0;
            cap_q    <= '0;
            signed_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid && rdy) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        signed_q <= req_signed;
                        data_q   <= '0;  // stores respond with zero
                        issue_q  <= '0;
                        cap_q    <= '0;
                        pend_q   <= 1'b0;
                        case (req_size)
                            2'd0:    n_q <= 3'd1;
                            2'd1:    n_q <= 3'd2;
                            default: n_q <= 3'd4;
                        endcase
                        state_q  <= req_we ? StWrite : StRead;
                    end
                end
                StRead: begin
                    if (!rdy) begin
                        // Bus lent out: read pipeline is broken, re-present the
                        // first uncaptured address once the bus comes back.
                        pend_q  <= 1'b0;
                        issue_q <= cap_q;
                    end else begin
                        pend_q <= 1'b1;
                        if (issue_q < n_q) begin
                            issue_q <= issue_q + 3'd1;
                        end
                        if (pend_q) begin
                            data_q[{cap_q[1:0], 3'b000} +: 8] <= mem_din;
                            cap_q <= cap_q + 3'd1;
                            if (cap_q == last_idx) begin
                                pend_q  <= 1'b0;
                                state_q <= StResp;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (wr_fire) begin
                        issue_q <= issue_q + 3'd1;
                        if (issue_q == last_idx) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
module tb_mem_byte_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        io_buffer_full;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    mem_byte_ctrl #(.IO_SEL_HI(17)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .io_buffer_full (io_buffer_full),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;   // expected response cycle, or -1 when not timed
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = -1000;   // cycle of the current handshake
    bit rand_mode = 1'b0;
    int rdy_lo = -1, rdy_hi = -2, io_lo = -1, io_hi = -2;

    logic [7:0] preset  [logic [31:0]];  // initial memory contents
    logic [7:0] bus_mem [logic [31:0]];  // bytes written over the bus
    logic [7:0] ref_mem [logic [31:0]];  // reference model's view of memory

    logic [31:0] tr_a    [0:15];
    logic        tr_wr   [0:15];
    logic [7:0]  tr_dout [0:15];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        if (preset.exists(a)) return preset[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (preset.exists(a)) return preset[a];
        return dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        preset[a] = b;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus side: RAM answers one cycle after the address; garbage while the HCI owns the bus.
    always @(posedge clk) begin
        if (mem_wr) bus_mem[mem_a] = mem_dout;
        mem_din <= rdy ? bus_rd(mem_a) : 8'($urandom);
    end

    // rdy / io_buffer_full: random, or windows relative to the handshake cycle.
    always @(posedge clk) begin
        int rel;
        #1;
        rel = cyc - t0;
        if (rand_mode) begin
            rdy            = ($urandom_range(0, 5) != 0);
            io_buffer_full = ($urandom_range(0, 2) == 0);
        end else begin
            rdy            = !(rel >= rdy_lo && rel <= rdy_hi);
            io_buffer_full = (rel >= io_lo && rel <= io_hi);
        end
    end

    // Monitor: trace capture, write-gating check, scoreboard pop on resp_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (t0 >= 0 && cyc - t0 >= 0 && cyc - t0 <= 15) begin
                tr_a[cyc - t0]    = mem_a;
                tr_wr[cyc - t0]   = mem_wr;
                tr_dout[cyc - t0] = mem_dout;
            end
            if (mem_wr) begin
                check("wr_gating", {31'd0, rdy && !(mem_a[17:16] == 2'b11 && io_buffer_full)},
                      32'd1);
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rdata", resp_rdata, mon_e.data);
                    if (mon_e.cyc >= 0) check("resp_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        exp_t        e;
        int          n;
        int          k;
        logic [31:0] mask;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        @(posedge clk);
        #1;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            check("handshake_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        t0 = cyc;
        e.data = '0;
        for (int j = 0; j < n; j++) begin
            if (we) ref_mem[addr + 32'(j)] = wdata[8*j +: 8];
            else    e.data = e.data | (32'(ref_rd(addr + 32'(j))) << (8*j));
        end
        if (!we && sgn && n < 4 && e.data[8*n-1]) begin
            mask   = (32'd1 << (8*n)) - 32'd1;
            e.data = e.data | ~mask;
        end
        e.cyc = (lat >= 0) ? t0 + lat : -1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 0;
        while (sb_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            check("resp_timeout", 32'd1, 32'd0);
            sb_q.delete();
        end
        t0 = -1000;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 2))
            0:       return 32'h0000_1000 + 32'($urandom_range(0, 31));
            1:       return 32'h0002_FFF0 + 32'($urandom_range(0, 31));
            default: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; req_valid = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        poke(32'h180, 8'h80);
        poke(32'h003, 8'h01); poke(32'h004, 8'h80);
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
        poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
        repeat (3) @(posedge clk);
        #2;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Word load: addresses 0x100..0x103 in cycles 1..4, response in cycle 6.
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 6);
        for (int j = 1; j <= 4; j++) check("wload_addr", tr_a[j], 32'h100 + 32'(j - 1));

        // Sign / zero extension.
        issue(1'b0, 2'd0, 1'b1, 32'h180, 32'h0, 3);
        issue(1'b0, 2'd0, 1'b0, 32'h180, 32'h0, 3);
        issue(1'b0, 2'd1, 1'b1, 32'h003, 32'h0, 4);

        // Word store: strobes in cycles 1..4, response in cycle 5, then read back.
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF, 5);
        for (int j = 1; j <= 4; j++) begin
            check("wstore_wr", {31'd0, tr_wr[j]}, 32'd1);
            check("wstore_dout", {24'd0, tr_dout[j]}, 32'(8'hEF >> 0) & 32'h0 |
                  ((32'hDEAD_BEEF >> (8*(j-1))) & 32'hFF));
        end
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 6);

        // I/O write hold: buffer full in cycles 1..3.
        io_lo = 1; io_hi = 3;
        issue(1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h0000_005C, 5);
        io_lo = -1; io_hi = -2;
        for (int j = 1; j <= 3; j++) check("io_hold_wr", {31'd0, tr_wr[j]}, 32'd0);
        check("io_release_wr", {31'd0, tr_wr[4]}, 32'd1);

        // Bus stall with address wrap: rdy low in cycles 2..3.
        rdy_lo = 2; rdy_hi = 3;
        issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 9);
        rdy_lo = -1; rdy_hi = -2;
        check("stall_reissue", tr_a[4], 32'hFFFF_FFFE);
        check("stall_wrap0", tr_a[6], 32'h0000_0000);
        check("stall_wrap1", tr_a[7], 32'h0000_0001);

        // Reset in cycle 2 of a word store: no response may follow.
        @(posedge clk);
        #1;
        req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h500;
        req_wdata = 32'h1234_5678; req_valid = 1'b1;
        @(negedge clk);
        check("rst_test_handshake", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
        check("mid_rst_a", mem_a, 32'd0);
        check("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (10) @(posedge clk);

        // Randomized traffic against the reference memory.
        rand_mode = 1'b1;
        for (int t = 0; t < 300; t++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), pick_addr(), $urandom, -1);
        end
        rand_mode = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
